// File: rtl/video_src_burst_packer.sv
`default_nettype none
// ============================================================================
// Module   : video_src_burst_packer
// Purpose  : Frame-aligned source switch for the camera-to-SDRAM path. Passes
//            one of NUM_CH pixel streams, changes source only at a vsync
//            rising edge, pads or truncates every frame to exactly
//            H_ACT*V_ACT words, and buffers the words in a FIFO that flags
//            when a full SDRAM burst is available.
// Ports    : clk, rst                 - pixel clock, async active-high reset
//            ch_sel                   - requested channel, taken at frame edge
//            in_data / in_valid       - packed per-channel pixels and strobes
//            in_vsync                 - shared vertical sync (rise = boundary)
//            rd_en / rd_data / rd_valid - FIFO pop port, 1-cycle read latency
//            burst_rdy                - FIFO holds at least BURST_LEN words
//            active_ch                - channel currently passed through
//            frame_done / frame_cnt   - completion pulse and frame counter
//            clr_err / err_*          - sticky error flags and their clear
// Revision : 1.0 - initial release
// ============================================================================
module video_src_burst_packer #(
    parameter int                NUM_CH     = 4,
    parameter int                DATA_W     = 16,
    parameter int                H_ACT      = 800,
    parameter int                V_ACT      = 480,
    parameter int                BURST_LEN  = 256,
    parameter int                FIFO_DEPTH = 512,
    parameter logic [DATA_W-1:0] FILL       = {DATA_W{1'b0}}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NUM_CH)-1:0]   ch_sel,
    input  logic [NUM_CH*DATA_W-1:0]    in_data,
    input  logic [NUM_CH-1:0]           in_valid,
    input  logic                        in_vsync,
    input  logic                        rd_en,
    input  logic                        clr_err,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    output logic                        burst_rdy,
    output logic [$clog2(NUM_CH)-1:0]   active_ch,
    output logic                        frame_done,
    output logic [15:0]                 frame_cnt,
    output logic                        err_ovf,
    output logic                        err_udf,
    output logic                        err_short,
    output logic                        err_long
);

    localparam int c_ch_w      = $clog2(NUM_CH);
    localparam int c_frame_pix = H_ACT * V_ACT;
    localparam int c_pix_w     = $clog2(c_frame_pix + 1);
    localparam int c_addr_w    = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w     = c_addr_w + 1;

    localparam logic [c_pix_w-1:0] c_pix_max = c_pix_w'(c_frame_pix);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_burst   = c_cnt_w'(BURST_LEN);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_active = 2'd1;
    localparam logic [1:0] c_st_pad    = 2'd2;

    logic [1:0]          r_state, w_state_nxt;
    logic                r_vs_q, r_vs_qq;
    logic                w_edge;
    logic [c_ch_w-1:0]   r_active_ch;
    logic [c_pix_w-1:0]  r_pix_cnt, w_pix_nxt, w_pix_inc, w_pix_after;
    logic                r_frame_done;
    logic [15:0]         r_frame_cnt;
    logic                r_err_ovf, r_err_udf, r_err_short, r_err_long;

    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_valid;
    logic                w_push_req, w_push, w_pop, w_can_push, w_empty;
    logic [DATA_W-1:0]   w_push_word;
    logic                w_load_ch, w_frame_evt;
    logic                w_set_ovf, w_set_short, w_set_long;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;

    assign w_edge     = r_vs_q & ~r_vs_qq;
    assign w_empty    = (r_count == '0);
    assign w_pop      = rd_en & ~w_empty;
    // A pop frees a slot in the same cycle, so a push at full is still legal.
    assign w_can_push = (r_count != c_depth) | w_pop;
    assign w_push     = w_push_req & w_can_push;
    assign w_pix_inc  = r_pix_cnt + 1'b1;

    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_active_ch == c_ch_w'(k)) begin
                w_sel_data  = in_data[k*DATA_W +: DATA_W];
                w_sel_valid = in_valid[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pix_nxt   = r_pix_cnt;
        w_pix_after = r_pix_cnt;
        w_push_req  = 1'b0;
        w_push_word = w_sel_data;
        w_load_ch   = 1'b0;
        w_frame_evt = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_short = 1'b0;
        w_set_long  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_edge) begin
                    w_state_nxt = c_st_active;
                    w_pix_nxt   = '0;
                    w_load_ch   = 1'b1;
                end
            end
            c_st_active: begin
                if (w_sel_valid) begin
                    if (r_pix_cnt != c_pix_max) begin
                        // Count advances even if the FIFO drops the word, so
                        // SDRAM addressing stays frame-aligned.
                        w_push_req  = 1'b1;
                        w_set_ovf   = ~w_can_push;
                        w_pix_after = w_pix_inc;
                    end else begin
                        w_set_long = 1'b1;
                    end
                end
                w_pix_nxt = w_pix_after;
                // Boundary test uses the count including a coincident pixel.
                if (w_edge) begin
                    if (w_pix_after == c_pix_max) begin
                        w_frame_evt = 1'b1;
                        w_load_ch   = 1'b1;
                        w_pix_nxt   = '0;
                    end else begin
                        w_set_short = 1'b1;
                        w_state_nxt = c_st_pad;
                    end
                end
            end
            c_st_pad: begin
                // Pad only when space exists: padding stalls, never drops.
                w_push_word = FILL;
                if (w_can_push) begin
                    w_push_req = 1'b1;
                    w_pix_nxt  = w_pix_inc;
                    if (w_pix_inc == c_pix_max) begin
                        w_frame_evt = 1'b1;
                        w_load_ch   = 1'b1;
                        w_pix_nxt   = '0;
                        w_state_nxt = c_st_active;
                    end
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_q       <= 1'b0;
            r_vs_qq      <= 1'b0;
            r_active_ch  <= '0;
            r_pix_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
            r_err_ovf    <= 1'b0;
            r_err_udf    <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
        end else begin
            r_vs_q       <= in_vsync;
            r_vs_qq      <= r_vs_q;
            r_pix_cnt    <= w_pix_nxt;
            r_frame_done <= w_frame_evt;
            if (w_load_ch)   r_active_ch <= ch_sel;
            if (w_frame_evt) r_frame_cnt <= r_frame_cnt + 16'd1;
            // Clear first, then set: a same-cycle error event wins.
            r_err_ovf   <= (r_err_ovf   & ~clr_err) | w_set_ovf;
            r_err_udf   <= (r_err_udf   & ~clr_err) | (rd_en & w_empty);
            r_err_short <= (r_err_short & ~clr_err) | w_set_short;
            r_err_long  <= (r_err_long  & ~clr_err) | w_set_long;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign burst_rdy  = (r_count >= c_burst);
    assign active_ch  = r_active_ch;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;
    assign err_ovf    = r_err_ovf;
    assign err_udf    = r_err_udf;
    assign err_short  = r_err_short;
    assign err_long   = r_err_long;

endmodule
`default_nettype wire

// File: tb/tb_video_src_burst_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_src_burst_packer
// Purpose  : Self-checking bench for video_src_burst_packer using an 8x4
//            frame, 8-word bursts and a 16-word FIFO. A queue-based frame
//            model predicts every output each cycle; directed sequences add
//            fixed expectations for the frame-boundary corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_src_burst_packer;

    localparam int          NUM_CH     = 4;
    localparam int          DATA_W     = 16;
    localparam int          H_ACT      = 8;
    localparam int          V_ACT      = 4;
    localparam int          BURST_LEN  = 8;
    localparam int          FIFO_DEPTH = 16;
    localparam logic [15:0] FILL       = 16'hF11F;
    localparam int          FP         = H_ACT * V_ACT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ch_sel = '0;
    logic [63:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic        in_vsync = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid, burst_rdy, frame_done;
    logic [1:0]  active_ch;
    logic [15:0] frame_cnt;
    logic        err_ovf, err_udf, err_short, err_long;

    video_src_burst_packer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .H_ACT(H_ACT), .V_ACT(V_ACT),
        .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .FILL(FILL)
    ) dut (
        .clk(clk), .rst(rst), .ch_sel(ch_sel), .in_data(in_data),
        .in_valid(in_valid), .in_vsync(in_vsync), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
        .burst_rdy(burst_rdy), .active_ch(active_ch), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .err_ovf(err_ovf), .err_udf(err_udf),
        .err_short(err_short), .err_long(err_long)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: frame phase, pixel budget used, FIFO contents.
    int          m_phase;     // 0 waiting for first frame, 1 collecting, 2 padding
    bit          m_vs1, m_vs2;
    int          m_ch, m_cnt, m_frames;
    logic [15:0] m_q[$];
    bit          m_rd_valid, m_done;
    logic [15:0] m_rd_data;
    bit          m_ovf, m_udf, m_short, m_long;

    logic [15:0] popped[$];
    bit          done_seen;

    typedef struct {
        bit rd;
        bit clr;
        bit exp_rd_valid;
        bit exp_udf;
        bit exp_ovf;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_vs1 = 0; m_vs2 = 0; m_ch = 0; m_cnt = 0; m_frames = 0;
        m_q.delete();
        m_rd_valid = 0; m_rd_data = '0; m_done = 0;
        m_ovf = 0; m_udf = 0; m_short = 0; m_long = 0;
    endtask

    task automatic model_step();
        bit          edge_now, pop, room, done, e_ovf, e_udf, e_short, e_long;
        logic [15:0] word;
        edge_now = m_vs1 && !m_vs2;
        m_vs2 = m_vs1;
        m_vs1 = in_vsync;
        e_udf = rd_en && (m_q.size() == 0);
        pop   = rd_en && (m_q.size() > 0);
        room  = (m_q.size() < FIFO_DEPTH) || pop;
        done = 0; e_ovf = 0; e_short = 0; e_long = 0;
        word = '0;
        if (pop) word = m_q.pop_front();
        if (m_phase == 0) begin
            if (edge_now) begin m_phase = 1; m_ch = int'(ch_sel); m_cnt = 0; end
        end else if (m_phase == 1) begin
            if (in_valid[m_ch]) begin
                if (m_cnt < FP) begin
                    if (room) m_q.push_back(in_data[m_ch*DATA_W +: DATA_W]);
                    else      e_ovf = 1;
                    m_cnt++;
                end else begin
                    e_long = 1;
                end
            end
            if (edge_now) begin
                if (m_cnt == FP) done = 1;
                else begin e_short = 1; m_phase = 2; end
            end
        end else begin
            if (room) begin
                m_q.push_back(FILL);
                m_cnt++;
                if (m_cnt == FP) done = 1;
            end
        end
        if (done) begin
            m_frames = (m_frames + 1) & 16'hFFFF;
            m_ch = int'(ch_sel); m_cnt = 0; m_phase = 1;
        end
        m_done = done;
        m_rd_valid = pop;
        if (pop) m_rd_data = word;
        m_ovf   = (m_ovf   && !clr_err) || e_ovf;
        m_udf   = (m_udf   && !clr_err) || e_udf;
        m_short = (m_short && !clr_err) || e_short;
        m_long  = (m_long  && !clr_err) || e_long;
    endtask

    task automatic check_all();
        chk("rd_valid",   rd_valid,   m_rd_valid);
        chk("rd_data",    rd_data,    m_rd_data);
        chk("burst_rdy",  burst_rdy,  m_q.size() >= BURST_LEN);
        chk("active_ch",  active_ch,  m_ch);
        chk("frame_done", frame_done, m_done);
        chk("frame_cnt",  frame_cnt,  m_frames);
        chk("err_ovf",    err_ovf,    m_ovf);
        chk("err_udf",    err_udf,    m_udf);
        chk("err_short",  err_short,  m_short);
        chk("err_long",   err_long,   m_long);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check_all();
        if (rd_valid)   popped.push_back(rd_data);
        if (frame_done) done_seen = 1;
    endtask

    task automatic pulse_edge();
        in_vsync = 1'b1; step();
        in_vsync = 1'b0; step();
        step();
    endtask

    task automatic send(input int ch, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_data = {$urandom, $urandom};
            in_data[ch*DATA_W +: DATA_W] = 16'(base + i);
            in_valid = 4'($urandom) | 4'(1 << ch);
            step();
        end
        in_valid = '0;
    endtask

    task automatic check_seq(input string name, input int base, input int n);
        int errs;
        errs = 0;
        if (popped.size() != n) errs++;
        else for (int i = 0; i < n; i++) if (popped[i] !== 16'(base + i)) errs++;
        chk(name, errs, 0);
    endtask

    initial begin
        int fills;
        vecs[0] = '{rd:1, clr:0, exp_rd_valid:0, exp_udf:1, exp_ovf:1};
        vecs[1] = '{rd:0, clr:0, exp_rd_valid:0, exp_udf:1, exp_ovf:1};
        vecs[2] = '{rd:0, clr:1, exp_rd_valid:0, exp_udf:0, exp_ovf:0};
        vecs[3] = '{rd:1, clr:1, exp_rd_valid:0, exp_udf:1, exp_ovf:0};
        vecs[4] = '{rd:0, clr:1, exp_rd_valid:0, exp_udf:0, exp_ovf:0};
        vecs[5] = '{rd:0, clr:0, exp_rd_valid:0, exp_udf:0, exp_ovf:0};

        model_reset();
        done_seen = 0;
        step(); step();
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_burst_rdy", burst_rdy, 0);
        rst = 1'b0;

        // Frame 1: 32 pixels on ch2, burst_rdy as the 8th word lands.
        ch_sel = 2'd2;
        pulse_edge();
        popped.delete();
        for (int i = 0; i < FP; i++) begin
            rd_en = (i >= 8);
            in_data = {$urandom, $urandom};
            in_data[2*DATA_W +: DATA_W] = 16'(i);
            in_valid = 4'($urandom) | 4'b0100;
            step();
            if (i < 8) chk("burst_rdy_fill", burst_rdy, (i >= 7));
        end
        in_valid = '0;
        done_seen = 0;
        pulse_edge();
        chk("f1_done", done_seen, 1);
        chk("f1_cnt", frame_cnt, 1);
        repeat (10) step();
        check_seq("f1_order", 0, FP);

        // Short frame: 20 pixels, then 12 pad words.
        popped.delete();
        send(2, 20, 16'h100);
        ch_sel = 2'd1;
        done_seen = 0;
        pulse_edge();
        chk("short_flag", err_short, 1);
        for (int i = 0; i < 40 && !done_seen; i++) step();
        chk("short_done", done_seen, 1);
        chk("short_cnt", frame_cnt, 2);
        repeat (6) step();
        fills = 0;
        foreach (popped[i]) if (popped[i] === FILL) fills++;
        chk("short_fills", fills, FP - 20);
        chk("short_words", popped.size(), FP);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("short_clr", err_short, 0);

        // Long frame: 40 pixels, 8 dropped.
        popped.delete();
        chk("long_ch", active_ch, 1);
        send(1, 40, 16'h200);
        chk("long_flag", err_long, 1);
        done_seen = 0;
        pulse_edge();
        chk("long_done", done_seen, 1);
        chk("long_cnt", frame_cnt, 3);
        chk("long_noshort", err_short, 0);
        repeat (6) step();
        check_seq("long_kept", 16'h200, FP);

        // Mid-frame channel request change.
        clr_err = 1'b1; step(); clr_err = 1'b0;
        popped.delete();
        send(1, 16, 16'h300);
        ch_sel = 2'd3;
        send(1, 16, 16'h310);
        chk("midsel_ch", active_ch, 1);
        pulse_edge();
        chk("midsel_newch", active_ch, 3);
        repeat (6) step();
        check_seq("midsel_order", 16'h300, FP);

        // Overflow with no reads, then underflow / clear via table.
        rd_en = 1'b0;
        popped.delete();
        send(3, 32, 16'h400);
        chk("ovf_flag", err_ovf, 1);
        done_seen = 0;
        pulse_edge();
        chk("ovf_done", done_seen, 1);
        chk("ovf_noshort", err_short, 0);
        rd_en = 1'b1;
        repeat (18) step();
        check_seq("ovf_kept", 16'h400, FIFO_DEPTH);
        foreach (vecs[i]) begin
            rd_en = vecs[i].rd;
            clr_err = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].exp_rd_valid);
            chk($sformatf("vec%0d_udf", i), err_udf, vecs[i].exp_udf);
            chk($sformatf("vec%0d_ovf", i), err_ovf, vecs[i].exp_ovf);
        end
        rd_en = 1'b0; clr_err = 1'b0;

        // Reset in the middle of padding.
        send(3, 5, 16'h500);
        pulse_edge();
        repeat (4) step();
        chk("pad_short", err_short, 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_burst_rdy", burst_rdy, 0);
        chk("rst_short", err_short, 0);
        step(); step();
        rst = 1'b0;
        ch_sel = 2'd2;
        rd_en = 1'b1;
        pulse_edge();
        popped.delete();
        send(2, 32, 16'h600);
        done_seen = 0;
        pulse_edge();
        chk("resume_done", done_seen, 1);
        chk("resume_cnt", frame_cnt, 1);
        repeat (6) step();
        check_seq("resume_order", 16'h600, FP);

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            in_data  = {$urandom, $urandom};
            in_valid = 4'($urandom) | 4'($urandom);
            rd_en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) in_vsync = 1'b1;
            else if ($urandom_range(0, 1) == 0) in_vsync = 1'b0;
            ch_sel  = 2'($urandom);
            clr_err = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
